bayer_plane_streamer: RTL and testbench
=======================================

// Module: bayer_plane_streamer
// PURPOSE
//  Transmit end of the colour-tagged pixel stream (valid/color/value/last) consumed by the
//  per-channel mean/statistics stage. Reads a planar RGB frame from single-port SRAM
//  (1-cycle read latency) and emits three planes in order RED, GREEN, BLUE.
//  Emits one last pulse per plane (3 per frame), then a done pulse. Push-only: no backpressure.
// PARAMETERS
//  MAX_SIZE  20  largest legal size_i (log2 pixels per plane); 2^20*255 fits a 28-bit sum
//  ADDR_W    22  SRAM address width (= MAX_SIZE+2, three planes)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       reset, asynchronous, active-low
//  start_i    in   1       1-cycle pulse: begin a frame; ignored while busy_o=1
//  size_i     in   5       log2(pixels per plane) = n+m for a 2^n x 2^m image; latched on start
//  hold_i     in   1       1 = issue no new SRAM reads this cycle (in-flight read still completes)
//  mem_rd_o   out  1       SRAM read enable
//  mem_addr_o out  ADDR_W  SRAM address; plane p, pixel k at (p<<size)+k
//  mem_data_i in   8       SRAM read data, valid the cycle after mem_rd_o
//  valid_o    out  1       pixel beat valid
//  color_o    out  2       0=RED 1=GREEN 2=BLUE (3 never driven)
//  value_o    out  8       pixel value
//  last_o     out  1       high with the final beat of each plane
//  busy_o     out  1       high from accepted start until done_o cycle inclusive
//  done_o     out  1       1-cycle pulse, cycle after the final BLUE beat
//  err_o      out  1       1-cycle pulse, start with size_i>MAX_SIZE; no transfer, stays IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0; asynchronous, any time, incl. mid-frame
//   (in-flight read discarded, no further beats, no done_o).
//  FSM: IDLE -start&legal-> READ; READ -final BLUE read issued-> DRAIN;
//   DRAIN -final beat emitted-> DONE; DONE -> IDLE (done_o=1 here, busy_o still 1).
//  READ: each cycle with hold_i=0 issue mem_rd_o=1 at (plane<<size)+pix; pix++;
//   pix wraps to 0 at 2^size-1 and plane++. hold_i=1: mem_rd_o=0, counters frozen.
//  Latency: read issued cycle t -> data at mem_data_i in t+1 -> registered to valid_o/value_o
//   in t+2. color and last travel in a 2-stage side pipeline aligned with data.
//  last tag = (pix==2^size-1) at issue time; exactly 3 last_o per frame, one per plane.
//  size_i=0: one pixel per plane -> every beat has last_o=1 (3 beats total).
//  valid_o=0 cycles: value_o/color_o hold previous values, last_o=0.
//  start_i while busy_o=1: ignored, no err_o. start_i in DONE cycle: ignored.
//  Beats per frame = 3*2^size exactly; gaps only where hold_i was asserted.
//  mem_addr_o holds its last value when mem_rd_o=0.
// STRUCTURE
//  isp_pkg: colour codes RED/GREEN/BLUE (2'd0/1/2), FSM state encoding, MAX_SIZE,
//   shared with the mean stage.
//  Sub-module plane_addr_gen: pix/plane counters, wrap, last-tag and address generation;
//   top holds FSM, read/side pipeline, output registers.
// TESTING
//  size_i=2, hold_i=0: 12 beats back-to-back, color 0,0,0,0,1x4,2x4; last_o on beats 4,8,12;
//   mem_addr_o 0..3,4..7,8..11; done_o 1 cycle after beat 12.
//  size_i=0: 3 beats, each last_o=1, colors 0,1,2, addrs 0,1,2; done_o next cycle.
//  size_i=2, hold_i high for 3 cycles mid-GREEN: exactly 3-cycle gap in valid_o,
//   values/order unchanged vs no-hold run, still 12 beats.
//  start_i with size_i=21: err_o pulse, busy_o=0, mem_rd_o never asserted.
//  Second start_i during frame: ignored, beat count still 12; rst_n low mid-RED: outputs 0
//   next cycle, no done_o; new start after release gives clean full frame.
//  Drive into mean stage, SRAM R=8,G=16,B=32 constant, size_i=4: means 8/16/32, finish asserted.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared ISP definitions: colour codes, streamer FSM encoding and frame-size limits.
// Imported by the plane streamer and by the downstream mean stage.
package isp_pkg;

  localparam int MAX_SIZE = 20;
  localparam int ADDR_W   = MAX_SIZE + 2;
  localparam int SIZE_W   = 5;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic size_legal(input logic [SIZE_W-1:0] size);
    return size <= SIZE_W'(MAX_SIZE);
  endfunction

endpackage

// File: rtl/bayer_plane_streamer_addr_gen.sv
// Pixel/plane counters for the planar frame walk: wraps pixel index per plane,
// tags the final pixel of each plane and forms the SRAM address (plane<<size)+pix.
module plane_addr_gen
  import isp_pkg::*;
#(
  parameter int MAX_SIZE = 20,
  parameter int ADDR_W   = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [4:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        plane,
  output logic              last,
  output logic              final_read
);

  localparam logic [MAX_SIZE-1:0] PIX_ONE = {{(MAX_SIZE-1){1'b0}}, 1'b1};
  localparam logic [MAX_SIZE:0]   SPAN_ONE = {{MAX_SIZE{1'b0}}, 1'b1};

  logic [MAX_SIZE-1:0] pix;
  logic [MAX_SIZE:0]   span;
  logic [MAX_SIZE-1:0] pix_max;

  // At size==MAX_SIZE the low bits of span are zero, so the subtraction wraps to all ones.
  always_comb begin
    span       = SPAN_ONE << size;
    pix_max    = span[MAX_SIZE-1:0] - PIX_ONE;
    last       = (pix == pix_max);
    final_read = last && (plane == 2'd2);
    addr       = ({{(ADDR_W-2){1'b0}}, plane} << size)
               | {{(ADDR_W-MAX_SIZE){1'b0}}, pix};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix   <= '0;
      plane <= '0;
    end else if (clear) begin
      pix   <= '0;
      plane <= '0;
    end else if (advance) begin
      if (last) begin
        pix   <= '0;
        plane <= plane + 2'd1;
      end else begin
        pix <= pix + PIX_ONE;
      end
    end
  end

endmodule

// File: rtl/bayer_plane_streamer.sv
// Streams a planar RGB frame out of 1-cycle-latency SRAM as colour-tagged beats
// (RED, GREEN, BLUE planes in order), with one last per plane and a done pulse.
//
// Handshake: push-only. A beat is transferred on every cycle with valid_o=1; the
// consumer must accept it. hold_i only throttles new SRAM reads, never a beat in flight.
module bayer_plane_streamer
  import isp_pkg::*;
#(
  parameter int MAX_SIZE = 20,
  parameter int ADDR_W   = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [4:0]        size_i,
  input  logic              hold_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic              valid_o,
  output logic [1:0]        color_o,
  output logic [7:0]        value_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output state_t            fsm_state
);

  state_t state, state_next;

  logic [4:0]        size_q;
  logic              legal;
  logic              accept;
  logic              issue;
  logic [ADDR_W-1:0] gen_addr;
  logic [1:0]        gen_plane;
  logic              gen_last;
  logic              gen_final;

  // Side pipeline: stage0 rides with mem_rd_o, stage1 with mem_data_i.
  logic [1:0] color0, color1;
  logic       last0, last1;
  logic       rd1;

  assign legal     = (size_i <= 5'(MAX_SIZE));
  assign accept    = (state == ST_IDLE) && start_i && legal;
  assign issue     = (state == ST_READ) && !hold_i;
  assign busy_o    = (state != ST_IDLE);
  assign done_o    = (state == ST_DONE);
  assign fsm_state = state;

  plane_addr_gen #(
    .MAX_SIZE (MAX_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .advance    (issue),
    .size       (size_q),
    .addr       (gen_addr),
    .plane      (gen_plane),
    .last       (gen_last),
    .final_read (gen_final)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_READ;
      ST_READ:  if (issue && gen_final) state_next = ST_DRAIN;
      // The final BLUE beat is the only beat with last_o set on the BLUE plane.
      ST_DRAIN: if (valid_o && last_o && (color_o == BLUE)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q <= '0;
      err_o  <= 1'b0;
    end else begin
      if (accept) size_q <= size_i;
      err_o <= (state == ST_IDLE) && start_i && !legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_o   <= 1'b0;
      mem_addr_o <= '0;
      color0     <= '0;
      last0      <= 1'b0;
    end else begin
      mem_rd_o <= issue;
      if (issue) begin
        mem_addr_o <= gen_addr;
        color0     <= gen_plane;
        last0      <= gen_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1     <= 1'b0;
      color1  <= '0;
      last1   <= 1'b0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      color_o <= '0;
      value_o <= '0;
    end else begin
      rd1     <= mem_rd_o;
      color1  <= color0;
      last1   <= last0;
      valid_o <= rd1;
      last_o  <= rd1 && last1;
      if (rd1) begin
        value_o <= mem_data_i;
        color_o <= color1;
      end
    end
  end

endmodule

// File: tb/tb_bayer_plane_streamer.sv
// Self-checking bench for bayer_plane_streamer: SRAM model, scoreboard of expected
// beats and read addresses, and one task per scenario.
module tb_bayer_plane_streamer;
  import isp_pkg::*;

  localparam int AW = 22;
  localparam int W  = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [4:0]    size_i = '0;
  logic          hold_i = 1'b0;
  logic          mem_rd_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_data_i = '0;
  logic          valid_o;
  logic [1:0]    color_o;
  logic [7:0]    value_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  state_t        fsm_state;

  bayer_plane_streamer #(.MAX_SIZE(20), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .size_i     (size_i),
    .hold_i     (hold_i),
    .mem_rd_o   (mem_rd_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .valid_o    (valid_o),
    .color_o    (color_o),
    .value_o    (value_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- SRAM model ----------------
  int mem_mode = 0;

  function automatic logic [7:0] sram_val(input logic [AW-1:0] a);
    if (mem_mode == 1) begin
      if (a < 16) return 8'd8;
      if (a < 32) return 8'd16;
      return 8'd32;
    end
    return a[7:0] * 8'd37 + a[15:8] + 8'd5;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_o) mem_data_i <= sram_val(mem_addr_o);
    else          mem_data_i <= 8'($urandom);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] addr_q[$];
  int cyc = 0;
  int rd_cnt, beat_cnt, done_cnt, err_cnt, gap_cyc, last_beat_cyc, done_cyc;
  int mean_sum[3];
  int mean_cnt[3];

  always @(negedge clk) begin
    logic [W-1:0]  e;
    logic [AW-1:0] a;
    cyc++;
    if (mem_rd_o) begin
      rd_cnt++;
      checks++;
      if (addr_q.size() == 0) begin
        failures++;
        $display("FAIL extra_read actual=addr%0d required=no_read", mem_addr_o);
      end else begin
        a = addr_q.pop_front();
        if (mem_addr_o !== a) begin
          failures++;
          $display("FAIL read_addr actual=%0d required=%0d", mem_addr_o, a);
        end
      end
    end
    if (valid_o) begin
      beat_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL extra_beat actual=%h required=no_beat", {color_o, last_o, value_o});
      end else begin
        e = exp_q.pop_front();
        if ({color_o, last_o, value_o} !== e) begin
          failures++;
          $display("FAIL beat actual=%h required=%h", {color_o, last_o, value_o}, e);
        end
      end
      if (last_o && color_o == 2'd2) last_beat_cyc = cyc;
      if (color_o < 2'd3) begin
        mean_sum[color_o] += int'(value_o);
        mean_cnt[color_o]++;
      end
    end else begin
      if (beat_cnt > 0 && exp_q.size() > 0) gap_cyc++;
      if (last_o) begin
        checks++;
        failures++;
        $display("FAIL idle_last actual=1 required=0");
      end
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (busy_o !== 1'b1) begin
        failures++;
        $display("FAIL busy_in_done actual=%b required=1", busy_o);
      end
    end
    if (err_o) err_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    exp_q.delete();
    addr_q.delete();
    rd_cnt = 0; beat_cnt = 0; done_cnt = 0; err_cnt = 0; gap_cyc = 0;
    last_beat_cyc = -1; done_cyc = -1;
    for (int c = 0; c < 3; c++) begin
      mean_sum[c] = 0;
      mean_cnt[c] = 0;
    end
  endtask

  task automatic start_frame(input logic [4:0] size);
    logic [AW-1:0] a;
    clear_stats();
    if (size <= 5'd20) begin
      for (int p = 0; p < 3; p++) begin
        for (int k = 0; k < (1 << size); k++) begin
          a = AW'((p << size) + k);
          addr_q.push_back(a);
          exp_q.push_back({2'(p), (k == (1 << size) - 1), sram_val(a)});
        end
      end
    end
    @(posedge clk); #1;
    size_i = size;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_reads(input int n, output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rd_cnt >= n) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_rd_o, valid_o, last_o, busy_o, done_o, err_o, value_o, color_o, mem_addr_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b%b%b%b%b%b required=000000",
               mem_rd_o, valid_o, last_o, busy_o, done_o, err_o);
    end
    checks++;
    if (fsm_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state actual=%0d required=%0d", fsm_state, ST_IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame(input string name, input logic [4:0] size, input int beats);
    logic to;
    start_frame(size);
    wait_done(2000, to);
    checks++;
    if (to) begin failures++; $display("FAIL %s_done_timeout actual=none required=done", name); end
    checks++;
    if (beat_cnt != beats) begin failures++; $display("FAIL %s_beats actual=%0d required=%0d", name, beat_cnt, beats); end
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      failures++;
      $display("FAIL %s_leftover actual=%0d/%0d required=0/0", name, exp_q.size(), addr_q.size());
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL %s_done_count actual=%0d required=1", name, done_cnt); end
    checks++;
    if (done_cyc != last_beat_cyc + 1) begin
      failures++;
      $display("FAIL %s_done_timing actual=%0d required=%0d", name, done_cyc, last_beat_cyc + 1);
    end
    checks++;
    if (gap_cyc != 0) begin failures++; $display("FAIL %s_gaps actual=%0d required=0", name, gap_cyc); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL %s_busy_after actual=%b required=0", name, busy_o); end
  endtask

  task automatic test_hold();
    logic to;
    start_frame(5'd2);
    wait_reads(5, to);
    hold_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold_i = 1'b0;
    wait_done(2000, to);
    checks++;
    if (to) begin failures++; $display("FAIL hold_done_timeout actual=none required=done"); end
    checks++;
    if (gap_cyc != 3) begin failures++; $display("FAIL hold_gap actual=%0d required=3", gap_cyc); end
    checks++;
    if (beat_cnt != 12 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL hold_beats actual=%0d required=12", beat_cnt);
    end
  endtask

  task automatic test_err();
    int busy_seen = 0;
    start_frame(5'd21);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy_o) busy_seen++;
    end
    checks++;
    if (err_cnt != 1) begin failures++; $display("FAIL err_pulse actual=%0d required=1", err_cnt); end
    checks++;
    if (rd_cnt != 0) begin failures++; $display("FAIL err_reads actual=%0d required=0", rd_cnt); end
    checks++;
    if (busy_seen != 0) begin failures++; $display("FAIL err_busy actual=%0d required=0", busy_seen); end
    checks++;
    if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL err_state actual=%0d required=0", fsm_state); end
  endtask

  task automatic test_restart_ignored();
    logic to;
    start_frame(5'd2);
    repeat (4) @(posedge clk);
    #1 size_i = 5'd0;
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done(2000, to);
    checks++;
    if (to || beat_cnt != 12 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL restart_beats actual=%0d required=12", beat_cnt);
    end
    checks++;
    if (err_cnt != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL restart_flags actual=err%0d_done%0d required=err0_done1", err_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic to;
    int snap;
    start_frame(5'd2);
    wait_reads(2, to);
    @(posedge clk); #1 rst_n = 1'b0;
    snap = beat_cnt;
    @(negedge clk);
    checks++;
    if ({mem_rd_o, valid_o, last_o, busy_o, done_o, err_o} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_outputs actual=%b%b%b%b%b%b required=000000",
               mem_rd_o, valid_o, last_o, busy_o, done_o, err_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    checks++;
    if (done_cnt != 0 || beat_cnt != snap) begin
      failures++;
      $display("FAIL midreset_quiet actual=done%0d_beats%0d required=done0_beats%0d", done_cnt, beat_cnt, snap);
    end
  endtask

  task automatic test_mean();
    logic to;
    int want[3] = '{8, 16, 32};
    mem_mode = 1;
    start_frame(5'd4);
    wait_done(2000, to);
    checks++;
    if (to || done_cnt != 1) begin failures++; $display("FAIL mean_finish actual=%0d required=1", done_cnt); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (mean_cnt[c] != 16 || mean_sum[c] / 16 != want[c]) begin
        failures++;
        $display("FAIL mean_c%0d actual=%0d/%0d required=%0d/16", c, mean_sum[c], mean_cnt[c], want[c]);
      end
    end
    mem_mode = 0;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_frame("size2", 5'd2, 12);
    test_frame("size0", 5'd0, 3);
    test_frame("size3", 5'd3, 24);
    test_hold();
    test_err();
    test_restart_ignored();
    test_reset_mid_frame();
    test_frame("after_reset", 5'd2, 12);
    test_mean();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
